// File: rtl/pipe_stage_reg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipe_stage_reg : valid/ready pipeline stage register with flush and freeze.
// Optional two-entry skid buffer when PIPE_STAGE_SKID_EN is defined.
// Revision 1.0
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              freeze,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic              in_fire;
   logic              out_fire;
   logic              load_in;

   assign main_valid = (state != EMPTY);
   assign out_valid  = main_valid & ~freeze & ~flush;
   assign out_data   = main_data;
   assign in_fire    = in_valid & in_ready;
   assign out_fire   = out_valid & out_ready;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic              load_skid;
   logic              load_from_skid;

   assign skid_valid = (state == FULL);
   // Registered ready: no combinational path from out_ready.
   assign in_ready   = ~skid_valid & ~freeze & ~flush & ~rst;
   assign occupancy  = state;
`else
   assign in_ready   = (~main_valid | out_ready) & ~freeze & ~flush & ~rst;
   assign occupancy  = {1'b0, state[0]};
`endif

   always_comb begin
      state_nxt = state;
      load_in   = 1'b0;
`ifdef PIPE_STAGE_SKID_EN
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
`endif
      case (state)
         EMPTY: begin
            if (in_fire) begin
               load_in   = 1'b1;
               state_nxt = ONE;
            end
         end
         ONE: begin
            if (in_fire) begin
`ifdef PIPE_STAGE_SKID_EN
               if (out_fire) begin
                  load_in = 1'b1;
               end else begin
                  load_skid = 1'b1;
                  state_nxt = FULL;
               end
`else
               // Single entry: accepting while occupied implies a same-cycle pop.
               load_in = 1'b1;
`endif
            end else if (out_fire) begin
               state_nxt = EMPTY;
            end
         end
`ifdef PIPE_STAGE_SKID_EN
         FULL: begin
            if (out_fire) begin
               load_from_skid = 1'b1;
               state_nxt      = ONE;
            end
         end
`endif
         default: state_nxt = EMPTY;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         state     <= EMPTY;
         main_data <= '0;
`ifdef PIPE_STAGE_SKID_EN
         skid_data <= '0;
`endif
      end else begin
         state <= state_nxt;
         if (load_in) begin
            main_data <= in_data;
         end
`ifdef PIPE_STAGE_SKID_EN
         else if (load_from_skid) begin
            main_data <= skid_data;
         end
         if (load_skid) begin
            skid_data <= in_data;
         end
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
`default_nettype none
// Testbench for pipe_stage_reg: queue-based reference model checked every cycle.
module tb_pipe_stage_reg;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        freeze = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_data;
   logic [1:0]  occupancy;

   int          n_checks = 0;
   int          n_errors = 0;
   logic [31:0] mq[$];
   logic [31:0] src[$];
   logic [31:0] last_data = '0;
   bit          init = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.DATA_W(32)) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .freeze    (freeze),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Drives n cycles from the pending source queue; model decides acceptance.
   task automatic run(input int n, input logic ordy, input logic frz, input logic fl, input logic rs);
      for (int i = 0; i < n; i++) begin
         logic        m_ir;
         logic        m_ov;
         logic        m_if;
         logic        m_of;
         logic [31:0] exp_d;
         in_valid  = (src.size() > 0);
         in_data   = (src.size() > 0) ? src[0] : 32'h0;
         out_ready = ordy;
         freeze    = frz;
         flush     = fl;
         rst       = rs;
         #1;
         m_ir = !frz && !fl && !rs;
`ifdef PIPE_STAGE_SKID_EN
         m_ir = m_ir && (mq.size() < 2);
`else
         m_ir = m_ir && ((mq.size() == 0) || ordy);
`endif
         m_ov  = (mq.size() > 0) && !frz && !fl;
         exp_d = (mq.size() > 0) ? mq[0] : last_data;
         if (init) begin
            check("in_ready",  {31'b0, in_ready},  {31'b0, m_ir});
            check("out_valid", {31'b0, out_valid}, {31'b0, m_ov});
            check("occupancy", {30'b0, occupancy}, 32'(mq.size()));
            check("out_data",  out_data, exp_d);
         end
         m_if = in_valid && m_ir;
         m_of = m_ov && ordy;
         @(posedge clk);
         if (rs || fl) begin
            mq.delete();
            last_data = '0;
            if (rs) init = 1'b1;
         end else begin
            if (m_of) last_data = mq.pop_front();
            if (m_if) mq.push_back(in_data);
         end
         if (m_if) void'(src.pop_front());
         @(negedge clk);
      end
   endtask

   initial begin
      // Reset
      run(2, 1'b0, 1'b0, 1'b0, 1'b1);
      check("rst_occ",  {30'b0, occupancy}, 32'd0);
      check("rst_data", out_data, 32'd0);

      // Streaming 1..8 with out_ready held high
      for (int v = 1; v <= 8; v++) src.push_back(32'(v));
      run(10, 1'b1, 1'b0, 1'b0, 1'b0);

      // Back-pressure: offer A, B, C with out_ready low, then drain
      src.push_back(32'hA);
      src.push_back(32'hB);
      src.push_back(32'hC);
      run(3, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PIPE_STAGE_SKID_EN
      check("bp_occ", {30'b0, occupancy}, 32'd2);
`else
      check("bp_occ", {30'b0, occupancy}, 32'd1);
`endif
      run(6, 1'b1, 1'b0, 1'b0, 1'b0);

      // Flush while holding A, B with C offered in the flush cycle
      src.push_back(32'hA);
      src.push_back(32'hB);
      run(2, 1'b0, 1'b0, 1'b0, 1'b0);
      src.push_back(32'hC);
      run(1, 1'b0, 1'b0, 1'b1, 1'b0);
      src.delete();
      check("fl_occ",  {30'b0, occupancy}, 32'd0);
      check("fl_data", out_data, 32'd0);
      run(2, 1'b1, 1'b0, 1'b0, 1'b0);

      // Freeze for 3 cycles while holding 0x55
      src.push_back(32'h55);
      run(1, 1'b0, 1'b0, 1'b0, 1'b0);
      src.push_back(32'h66);
      run(3, 1'b1, 1'b1, 1'b0, 1'b0);
      check("frz_occ",  {30'b0, occupancy}, 32'd1);
      check("frz_data", out_data, 32'h55);
      run(4, 1'b1, 1'b0, 1'b0, 1'b0);

      // Reset mid-stream with storage filled
      src.push_back(32'h1);
      src.push_back(32'h2);
      run(2, 1'b0, 1'b0, 1'b0, 1'b0);
      src.delete();
      run(1, 1'b0, 1'b0, 1'b0, 1'b1);
      check("mrst_occ",  {30'b0, occupancy}, 32'd0);
      check("mrst_data", out_data, 32'd0);
      run(1, 1'b0, 1'b0, 1'b0, 1'b0);

      // Single-entry style pass-through: 0x1 then 0x2 with out_ready low, then high
      src.push_back(32'h1);
      src.push_back(32'h2);
      run(2, 1'b0, 1'b0, 1'b0, 1'b0);
      run(3, 1'b1, 1'b0, 1'b0, 1'b0);

      // Randomised mix of back-pressure, freeze and occasional flush
      for (int k = 0; k < 80; k++) begin
         if (src.size() == 0) src.push_back($urandom);
         run(1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
             1'($urandom_range(0, 19) == 0), 1'b0);
      end
      src.delete();
      run(4, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
